bf16_dot_accum: RTL and testbench

- Sits directly downstream of the 16-lane bf16 element-wise multiplier array.
- Consumes one 256-bit beat of 16 bf16 products per cycle and reduces them through a pipelined adder tree.
- Accumulates the per-beat sums across a first..last sequence of beats.
- Emits one bf16 dot-product result per sequence, with a valid/ready handshake on both sides.

---
 rtl/bf16_dot_accum.sv | 127 ++++++++++++
 tb/tb_bf16_dot_accum.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_dot_accum.sv
// Reduces 16-lane bf16 product beats through a registered adder tree and accumulates beat sums
// over first..last sequences; result 5 edges after acceptance; whole pipe freezes while a result waits.
module bf16_dot_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_SIZE   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*ROW_SIZE-1:0] in_data,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CNT_WIDTH-1:0]           out_beats,
  output logic                           out_valid,
  input  logic                           out_ready
);

  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    logic [7:0]  d;
    logic [18:0] ax, ay;
    logic [19:0] n0, n;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic [7:0]  fr;
    logic        x_nan, y_nan, x_inf, y_inf, rnd;
    x = (a[14:7] == 8'h00) ? {a[15], 15'h0} : a;
    y = (b[14:7] == 8'h00) ? {b[15], 15'h0} : b;
    x_nan = (x[14:7] == 8'hFF) && (x[6:0] != 7'h0);
    y_nan = (y[14:7] == 8'hFF) && (y[6:0] != 7'h0);
    x_inf = (x[14:0] == 15'h7F80);
    y_inf = (y[14:0] == 15'h7F80);
    if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15]))) return 16'h7FC0;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x[14:0] == 15'h0 && y[14:0] == 15'h0) return {x[15] & y[15], 15'h0};
    if (x[14:0] == 15'h0) return y;
    if (y[14:0] == 15'h0) return x;
    if (y[14:0] > x[14:0]) begin
      t = x;
      x = y;
      y = t;
    end
    d = x[14:7] - y[14:7];
    // Beyond 11 bits of alignment the smaller operand is under 1/16 ulp and cannot change the RNE result.
    if (d > 8'd11) return x;
    ax = {1'b1, x[6:0], 11'h0};
    ay = {1'b1, y[6:0], 11'h0} >> d;
    n0 = (x[15] == y[15]) ? ({1'b0, ax} + {1'b0, ay}) : ({1'b0, ax} - {1'b0, ay});
    lz = '0;
    for (int i = 0; i < 20; i++) begin
      if (n0[i]) lz = 5'(19 - i);
    end
    n = n0 << lz;
    if (!n[19]) return 16'h0000;
    e   = {2'b00, x[14:7]} + 10'd1 - {5'b0, lz};
    rnd = n[11] & ((|n[10:0]) | n[12]);
    fr  = {1'b0, n[18:12]} + {7'h0, rnd};
    if (fr[7]) e = e + 10'd1;
    if (e[9] || e == 10'd0) return 16'h0000;
    if (e >= 10'd255) return {x[15], 8'hFF, 7'h0};
    return {x[15], e[7:0], fr[6:0]};
  endfunction

  logic                  advance;
  logic [15:0]           s0_dat [16];
  logic [15:0]           s1_dat [8];
  logic [15:0]           s2_dat [4];
  logic [15:0]           s3_dat [2];
  logic [15:0]           s4_dat;
  logic [4:0]            vld, fst, lst;
  logic [15:0]           acc, acc_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Data path needs no reset: every stage is qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < 16; i++) s0_dat[i] <= in_data[DATA_WIDTH*(ROW_SIZE-i)-1 -: 16];
      for (int k = 0; k < 8; k++)  s1_dat[k] <= bf16_add(s0_dat[2*k], s0_dat[2*k+1]);
      for (int k = 0; k < 4; k++)  s2_dat[k] <= bf16_add(s1_dat[2*k], s1_dat[2*k+1]);
      for (int k = 0; k < 2; k++)  s3_dat[k] <= bf16_add(s2_dat[2*k], s2_dat[2*k+1]);
      s4_dat <= bf16_add(s3_dat[0], s3_dat[1]);
    end
  end

  always_comb begin
    acc_nxt = bf16_add(acc, s4_dat);
    cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
    if (fst[4]) begin
      acc_nxt = s4_dat;
      cnt_nxt = CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld       <= '0;
      fst       <= '0;
      lst       <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (advance) begin
      vld       <= {vld[3:0], in_valid};
      fst       <= {fst[3:0], in_first};
      lst       <= {lst[3:0], in_last};
      out_valid <= vld[4] && lst[4];
      if (vld[4]) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        if (lst[4]) begin
          out_data  <= acc_nxt;
          out_beats <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_bf16_dot_accum.sv
// Scoreboard bench for bf16_dot_accum: a double-precision reference model predicts every result.
module tb_bf16_dot_accum;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_first, in_last, in_ready, out_valid, out_ready;
  logic [255:0] in_data;
  logic [15:0]  out_data, out_beats;

  bf16_dot_accum dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_beats(out_beats),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] d; logic [15:0] b;} res_t;
  res_t        exp_q[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [15:0] macc = 16'h0, mcnt = 16'h0;
  logic        dir_vld = 1'b0, rand_bp = 1'b0;
  logic [15:0] dir_dat, dir_beats;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real b2r(input logic [15:0] h);
    logic [10:0] e11;
    if (h[14:7] == 8'h0) return $bitstoreal({h[15], 63'h0});
    e11 = {3'b0, h[14:7]} + 11'd896;
    return $bitstoreal({h[15], e11, h[6:0], 45'h0});
  endfunction

  function automatic logic [15:0] r2b(input real r);
    logic [63:0] bits;
    logic [8:0]  m;
    int          e;
    bits = $realtobits(r);
    if (bits[62:52] == 11'h0) return {bits[63], 15'h0};
    e = int'(bits[62:52]) - 896;
    m = {2'b01, bits[51:45]};
    if (bits[44] && ((|bits[43:0]) || m[0])) m = m + 9'd1;
    if (m[8]) begin
      m = 9'h080;
      e++;
    end
    if (e >= 255) return {bits[63], 8'hFF, 7'h0};
    if (e <= 0) return 16'h0000;
    return {bits[63], 8'(e), m[6:0]};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    x = (a[14:7] == 8'h0) ? {a[15], 15'h0} : a;
    y = (b[14:7] == 8'h0) ? {b[15], 15'h0} : b;
    if ((x[14:7] == 8'hFF && x[6:0] != 0) || (y[14:7] == 8'hFF && y[6:0] != 0)) return 16'h7FC0;
    if (x[14:0] == 15'h7F80 && y[14:0] == 15'h7F80) return (x == y) ? x : 16'h7FC0;
    if (x[14:0] == 15'h7F80) return x;
    if (y[14:0] == 15'h7F80) return y;
    return r2b(b2r(x) + b2r(y));
  endfunction

  function automatic logic [15:0] beat_sum(input logic [255:0] d);
    logic [15:0] v[16];
    for (int i = 0; i < 16; i++) v[i] = d[255-16*i -: 16];
    for (int w = 8; w >= 1; w = w / 2)
      for (int k = 0; k < w; k++) v[k] = ref_add(v[2*k], v[2*k+1]);
    return v[0];
  endfunction

  task automatic model_accept(input logic [255:0] d, input logic f, input logic l);
    logic [15:0] s;
    s = beat_sum(d);
    if (f) begin
      macc = s;
      mcnt = 16'd1;
    end else begin
      macc = ref_add(macc, s);
      if (mcnt != 16'hFFFF) mcnt++;
    end
    if (l) begin
      exp_q.push_back(dir_vld ? {dir_dat, dir_beats} : {macc, mcnt});
      dir_vld = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] fill(input logic [15:0] v, input int lane, input logic [15:0] lv);
    logic [255:0] d;
    for (int i = 0; i < 16; i++) d[255-16*i -: 16] = (i == lane) ? lv : v;
    return d;
  endfunction

  function automatic logic [15:0] rnd_bf16();
    logic [15:0] sp[8];
    sp = '{16'h7F80, 16'hFF80, 16'h7FC0, 16'h0000, 16'h8000, 16'h0003, 16'h7F7F, 16'hFF7F};
    if ($urandom_range(0, 63) == 0) return sp[$urandom_range(0, 7)];
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 7'($urandom_range(0, 127))};
  endfunction

  function automatic logic [255:0] rnd_beat();
    logic [255:0] d;
    for (int i = 0; i < 16; i++) d[255-16*i -: 16] = rnd_bf16();
    return d;
  endfunction

  task automatic send(input logic [255:0] d, input logic f, input logic l);
    int   guard;
    logic ok;
    guard = 0;
    in_data = d; in_first = f; in_last = l; in_valid = 1'b1;
    forever begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        model_accept(d, f, l);
        break;
      end
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout beat not accepted within 500 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic sendx(input logic [255:0] d, input logic f, input logic l,
                       input logic [15:0] ed, input logic [15:0] eb);
    dir_vld = 1'b1; dir_dat = ed; dir_beats = eb;
    send(d, f, l);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=%h/%h required=none", out_data, out_beats);
      end else begin
        e = exp_q.pop_front();
        check("result_data", {16'h0, out_data}, {16'h0, e.d});
        check("result_beats", {16'h0, out_beats}, {16'h0, e.b});
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, c0;
    logic [255:0] ones, alt;
    ones = fill(16'h3F80, -1, 16'h0);
    alt  = '0;
    for (int i = 0; i < 16; i++) alt[255-16*i -: 16] = (i % 2 == 0) ? 16'h3F80 : 16'hBF80;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", {31'h0, out_valid}, 0);
    check("reset_out_data", {16'h0, out_data}, 0);
    check("reset_out_beats", {16'h0, out_beats}, 0);
    check("reset_in_ready", {31'h0, in_ready}, 1);

    // single beat, latency
    sendx(ones, 1, 1, 16'h4180, 16'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 5);
    idle(3);

    // two-beat sequence, then back-to-back singles
    send(ones, 1, 0);
    sendx(ones, 0, 1, 16'h4200, 16'd2);
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(rnd_beat(), 1, 1);
    check("throughput_cycles", cyc - c0, 8);
    idle(8);

    // special values
    sendx(alt, 1, 1, 16'h0000, 16'd1);
    sendx(fill(16'h3F80, 5, 16'h7FC0), 1, 1, 16'h7FC0, 16'd1);
    sendx(fill(16'h7F7F, -1, 16'h0), 1, 1, 16'h7F80, 16'd1);
    sendx(fill(16'h0000, 0, 16'h0001), 1, 1, 16'h0000, 16'd1);
    idle(8);

    // backpressure
    out_ready = 1'b0;
    sendx(ones, 1, 1, 16'h4180, 16'd1);
    sendx(fill(16'h4000, -1, 16'h0), 1, 1, 16'h4200, 16'd1);
    idle(8);
    in_data = alt; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'h0, in_ready}, 0);
      check("stall_out_data", {16'h0, out_data}, 32'h4180);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    sendx(alt, 1, 1, 16'h0000, 16'd1);
    idle(10);

    // reset in the middle of a 3-beat sequence
    send(ones, 1, 0);
    in_data = ones; in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete(); macc = 16'h0; mcnt = 16'h0;
    for (int i = 0; i < 8; i++) begin
      check("no_out_after_rst", {31'h0, out_valid}, 0);
      @(posedge clk); #1;
    end
    sendx(fill(16'h4000, -1, 16'h0), 1, 1, 16'h4200, 16'd1);
    idle(8);

    // randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(rnd_beat(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    send(rnd_beat(), 0, 1);
    rand_bp = 1'b0; out_ready = 1'b1;
    idle(12);

    // counter saturation
    send('0, 1, 0);
    for (int i = 0; i < 69998; i++) send('0, 0, 0);
    sendx('0, 0, 1, 16'h0000, 16'hFFFF);
    idle(12);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
